// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC init sequencer (macro RTC_INIT_READBACK_EN adds readback states).
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package rtc_pkg;

  localparam int unsigned PULSE_CYC_DEF = 4;
  localparam int unsigned HOLD_CYC_DEF  = 2;
  localparam logic [7:0]  RTC_TERM      = 8'hFF;
  localparam logic [3:0]  IDX_MAX       = 4'hF;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    ADDR_LO,
    ADDR_HI,
    DATA_LO,
    DATA_HI,
    FINISH
`ifdef RTC_INIT_READBACK_EN
    ,
    RADDR_LO,
    RADDR_HI,
    RD_LO,
    RD_HI
`endif
  } state_e;

endpackage

// File: rtl/rtc_bus_strobe.sv
// Phase counter and strobe decode for the RTC bus (macro RTC_INIT_READBACK_EN adds rd_n_o).
// Latency: strobes decode combinationally from state; last_o flags the final cycle of a phase.
// Backpressure: none; phase lengths are fixed by PULSE_CYC/HOLD_CYC.
module rtc_bus_strobe
  import rtc_pkg::*;
#(
  parameter int unsigned PULSE_CYC = PULSE_CYC_DEF,
  parameter int unsigned HOLD_CYC  = HOLD_CYC_DEF
) (
  input  logic   clk,
  input  logic   reset_n,
  input  state_e state_i,
  input  logic   clr_i,
  output logic   last_o,
  output logic   cs_n_o,
  output logic   wr_n_o,
  output logic   a_d_o
`ifdef RTC_INIT_READBACK_EN
  ,
  output logic   rd_n_o
`endif
);

  localparam int unsigned MAX_CYC = (PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d, len_m1;
  logic lo_ph, hi_ph, data_ph;
`ifdef RTC_INIT_READBACK_EN
  logic rd_ph;
`endif

  // Classify the current state into strobe-low / strobe-high and address / data phases.
  always_comb begin
    lo_ph   = 1'b0;
    hi_ph   = 1'b0;
    data_ph = 1'b0;
`ifdef RTC_INIT_READBACK_EN
    rd_ph   = 1'b0;
`endif
    case (state_i)
      ADDR_LO:  lo_ph = 1'b1;
      ADDR_HI:  hi_ph = 1'b1;
      DATA_LO:  begin lo_ph = 1'b1; data_ph = 1'b1; end
      DATA_HI:  begin hi_ph = 1'b1; data_ph = 1'b1; end
`ifdef RTC_INIT_READBACK_EN
      RADDR_LO: lo_ph = 1'b1;
      RADDR_HI: hi_ph = 1'b1;
      RD_LO:    begin lo_ph = 1'b1; data_ph = 1'b1; rd_ph = 1'b1; end
      RD_HI:    begin hi_ph = 1'b1; data_ph = 1'b1; rd_ph = 1'b1; end
`endif
      default:  ;
    endcase
  end

  // One shared counter times every phase; it restarts whenever the state moves.
  always_comb begin
    len_m1 = lo_ph ? CNT_W'(PULSE_CYC - 1) : CNT_W'(HOLD_CYC - 1);
    cnt_d  = (clr_i || !(lo_ph || hi_ph)) ? '0 : cnt_q + CNT_W'(1);
  end

  // Phase counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign last_o = (lo_ph || hi_ph) && (cnt_q == len_m1);
  assign cs_n_o = ~(lo_ph | hi_ph);
  assign a_d_o  = data_ph;
`ifdef RTC_INIT_READBACK_EN
  assign wr_n_o = ~(lo_ph & ~rd_ph);
  assign rd_n_o = ~(lo_ph & rd_ph);
`else
  assign wr_n_o = ~lo_ph;
`endif

endmodule

// File: rtl/rtc_init_sequencer.sv
// Walks an external init ROM and writes each byte to the RTC over a muxed A/D bus (macro RTC_INIT_READBACK_EN adds verify-by-readback).
// Latency: 1 + 2*(PULSE_CYC+HOLD_CYC) cycles per entry (doubled with readback), plus FETCH and FINISH.
// Backpressure: none; start is only accepted in IDLE, ignored while busy.
module rtc_init_sequencer
  import rtc_pkg::*;
#(
  parameter int unsigned PULSE_CYC = PULSE_CYC_DEF,
  parameter int unsigned HOLD_CYC  = HOLD_CYC_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  output logic [3:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic       cs_n,
  output logic       a_d,
  output logic       wr_n,
  output logic [7:0] ad_out,
  output logic       busy,
  output logic       done
`ifdef RTC_INIT_READBACK_EN
  ,
  output logic       rd_n,
  input  logic [7:0] ad_in,
  output logic       err
`endif
);

  state_e     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] data_q, data_d;
  logic       busy_q, busy_d;
  logic       last;
`ifdef RTC_INIT_READBACK_EN
  logic       err_q, err_d;
`endif

  rtc_bus_strobe #(
    .PULSE_CYC (PULSE_CYC),
    .HOLD_CYC  (HOLD_CYC)
  ) u_strobe (
    .clk     (clk),
    .reset_n (reset_n),
    .state_i (state_q),
    .clr_i   (state_d != state_q),
    .last_o  (last),
    .cs_n_o  (cs_n),
    .wr_n_o  (wr_n),
    .a_d_o   (a_d)
`ifdef RTC_INIT_READBACK_EN
    ,
    .rd_n_o  (rd_n)
`endif
  );

  // Next-state, table index and data latch; phases advance on the counter's last cycle.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    data_d   = data_q;
    busy_d   = busy_q;
    done     = 1'b0;
    rom_addr = idx_q;
`ifdef RTC_INIT_READBACK_EN
    err_d    = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d   = 4'h0;
          busy_d  = 1'b1;
          state_d = FETCH;
`ifdef RTC_INIT_READBACK_EN
          err_d   = 1'b0;
`endif
        end
      end
      FETCH: begin
        // Index 15 terminates even without a marker so idx never wraps.
        if (rom_data == RTC_TERM || idx_q == IDX_MAX) begin
          state_d = FINISH;
        end else begin
          data_d  = rom_data;
          state_d = ADDR_LO;
        end
      end
      ADDR_LO: if (last) state_d = ADDR_HI;
      ADDR_HI: if (last) state_d = DATA_LO;
      DATA_LO: if (last) state_d = DATA_HI;
      DATA_HI: begin
        if (last) begin
`ifdef RTC_INIT_READBACK_EN
          state_d = RADDR_LO;
`else
          idx_d   = idx_q + 4'd1;
          state_d = FETCH;
`endif
        end
      end
`ifdef RTC_INIT_READBACK_EN
      RADDR_LO: if (last) state_d = RADDR_HI;
      RADDR_HI: if (last) state_d = RD_LO;
      RD_LO: begin
        if (last) begin
          // Sample on the final low cycle, when the RTC has had the longest to drive.
          if (ad_in != data_q) err_d = 1'b1;
          state_d = RD_HI;
        end
      end
      RD_HI: begin
        if (last) begin
          idx_d   = idx_q + 4'd1;
          state_d = FETCH;
        end
      end
`endif
      FINISH: begin
        done    = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus value: register index during address phases, latched ROM byte during data write.
  always_comb begin
    ad_out = 8'h00;
    case (state_q)
      ADDR_LO, ADDR_HI: ad_out = {4'h0, idx_q};
      DATA_LO, DATA_HI: ad_out = data_q;
`ifdef RTC_INIT_READBACK_EN
      RADDR_LO, RADDR_HI: ad_out = {4'h0, idx_q};
`endif
      default: ad_out = 8'h00;
    endcase
  end

  // State and datapath registers; reset abandons any run in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= 4'h0;
      data_q  <= 8'h00;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
    end
  end

`ifdef RTC_INIT_READBACK_EN
  // Sticky readback error, cleared only when a new run is accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= err_d;
  end

  assign err = err_q;
`endif

  assign busy = busy_q;

endmodule

// File: tb/tb_rtc_init_sequencer.sv
// Directed bench for rtc_init_sequencer with an RTC register model on the bus (macro RTC_INIT_READBACK_EN enables readback checks).
// Latency: n/a.
// Backpressure: n/a.
module tb_rtc_init_sequencer;

  localparam int P = 4;
  localparam int H = 2;
`ifdef RTC_INIT_READBACK_EN
  localparam int ENTRY = 1 + 4 * (P + H);
`else
  localparam int ENTRY = 1 + 2 * (P + H);
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       start = 1'b0;
  logic [3:0] rom_addr;
  logic [7:0] rom_data;
  logic       cs_n, a_d, wr_n, busy, done;
  logic [7:0] ad_out;
`ifdef RTC_INIT_READBACK_EN
  logic       rd_n, err;
  logic [7:0] ad_in;
  logic       bad_reg4 = 1'b0;
`endif

  logic [7:0] rom [16];
  logic [7:0] regs [16];
  logic [7:0] lat_addr = 8'h00;
  int         nwrites = 0;
  int         cs_cycles = 0;
  logic       prev_idle = 1'b1;
  int         wr_log[$];

  int total = 0;
  int bad = 0;

  assign rom_data = rom[rom_addr];
`ifdef RTC_INIT_READBACK_EN
  assign ad_in = (bad_reg4 && lat_addr == 8'h04) ? 8'h5A : regs[lat_addr[3:0]];
`endif

  rtc_init_sequencer #(.PULSE_CYC(P), .HOLD_CYC(H)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .cs_n     (cs_n),
    .a_d      (a_d),
    .wr_n     (wr_n),
    .ad_out   (ad_out),
    .busy     (busy),
    .done     (done)
`ifdef RTC_INIT_READBACK_EN
    ,
    .rd_n     (rd_n),
    .ad_in    (ad_in),
    .err      (err)
`endif
  );

  always #5 clk = ~clk;

  // RTC register model: latch address on an address strobe, store on a data strobe.
  always @(negedge clk) begin
    if (!cs_n) cs_cycles++;
    if (!cs_n && !wr_n && !a_d) lat_addr = ad_out;
    if (!cs_n && !wr_n && a_d) begin
      if (prev_idle) begin
        nwrites++;
        wr_log.push_back(int'(lat_addr));
      end
      regs[lat_addr[3:0]] = ad_out;
    end
    prev_idle = !(!cs_n && !wr_n && a_d);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic clear_model();
    for (int i = 0; i < 16; i++) regs[i] = 8'hEE;
    nwrites = 0;
    cs_cycles = 0;
    wr_log.delete();
  endtask

  task automatic load_table1();
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    rom[4] = 8'h01;
    rom[5] = 8'h01;
    rom[9] = 8'hFF;
  endtask

  // Leaves the bench at the negedge of cycle 1 (first cycle after start is sampled).
  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic goto(inout int cyc, input int target);
    while (cyc < target) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic wait_done(inout int cyc, input int limit);
    while (done !== 1'b1 && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (cs_n !== 1'b1)     begin bad++; $display("FAIL reset_cs_n got=%b exp=1", cs_n); end
    total++; if (wr_n !== 1'b1)     begin bad++; $display("FAIL reset_wr_n got=%b exp=1", wr_n); end
    total++; if (a_d !== 1'b0)      begin bad++; $display("FAIL reset_a_d got=%b exp=0", a_d); end
    total++; if (ad_out !== 8'h00)  begin bad++; $display("FAIL reset_ad_out got=%h exp=00", ad_out); end
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0)     begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (cs_n !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL idle_no_start got=cs_n%b/busy%b exp=1/0", cs_n, busy); end
  endtask

  task automatic test_table_run();
    int cyc;
    load_table1();
    clear_model();
    pulse_start();
    cyc = 1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL run_busy_c1 got=%b exp=1", busy); end
    total++; if (cs_n !== 1'b1) begin bad++; $display("FAIL run_fetch_cs_n got=%b exp=1", cs_n); end
    goto(cyc, 2);
    total++; if ({cs_n, a_d, wr_n} !== 3'b000 || ad_out !== 8'h00) begin bad++; $display("FAIL run_addr_lo got=%b%b%b/%h exp=000/00", cs_n, a_d, wr_n, ad_out); end
    goto(cyc, 2 + P);
    total++; if ({cs_n, a_d, wr_n} !== 3'b001) begin bad++; $display("FAIL run_addr_hi got=%b%b%b exp=001", cs_n, a_d, wr_n); end
    goto(cyc, 2 + P + H);
    total++; if ({cs_n, a_d, wr_n} !== 3'b010) begin bad++; $display("FAIL run_data_lo got=%b%b%b exp=010", cs_n, a_d, wr_n); end
    goto(cyc, 2 + ENTRY);
    total++; if (ad_out !== 8'h01 || wr_n !== 1'b0 || a_d !== 1'b0) begin bad++; $display("FAIL run_entry1_addr got=%h exp=01", ad_out); end
    wait_done(cyc, 400);
    total++; if (cyc !== 1 + 9 * ENTRY + 1) begin bad++; $display("FAIL run_done_cycle got=%0d exp=%0d", cyc, 1 + 9 * ENTRY + 1); end
    total++; if (nwrites !== 9) begin bad++; $display("FAIL run_nwrites got=%0d exp=9", nwrites); end
    for (int i = 0; i < 9; i++) begin
      total++; if (regs[i] !== rom[i]) begin bad++; $display("FAIL run_reg%0d got=%h exp=%h", i, regs[i], rom[i]); end
    end
    total++; if (regs[9] !== 8'hEE) begin bad++; $display("FAIL run_reg9_untouched got=%h exp=ee", regs[9]); end
    for (int i = 0; i < wr_log.size(); i++) begin
      total++; if (wr_log[i] !== i) begin bad++; $display("FAIL run_addr_order%0d got=%0d exp=%0d", i, wr_log[i], i); end
    end
    @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL run_after_done got=busy%b/done%b exp=0/0", busy, done); end
`ifdef RTC_INIT_READBACK_EN
    total++; if (err !== 1'b0) begin bad++; $display("FAIL run_err got=%b exp=0", err); end
`endif
  endtask

  task automatic test_first_term();
    int cyc;
    for (int i = 0; i < 16; i++) rom[i] = 8'h10;
    rom[0] = 8'hFF;
    clear_model();
    pulse_start();
    cyc = 1;
    wait_done(cyc, 50);
    total++; if (cyc !== 2) begin bad++; $display("FAIL term0_done_cycle got=%0d exp=2", cyc); end
    @(negedge clk);
    total++; if (cs_cycles !== 0) begin bad++; $display("FAIL term0_cs_activity got=%0d exp=0", cs_cycles); end
  endtask

  task automatic test_no_term();
    int cyc;
    for (int i = 0; i < 16; i++) rom[i] = 8'h30 + 8'(i);
    clear_model();
    pulse_start();
    cyc = 1;
    wait_done(cyc, 600);
    total++; if (cyc !== 1 + 15 * ENTRY + 1) begin bad++; $display("FAIL noterm_done_cycle got=%0d exp=%0d", cyc, 1 + 15 * ENTRY + 1); end
    total++; if (nwrites !== 15) begin bad++; $display("FAIL noterm_nwrites got=%0d exp=15", nwrites); end
    total++; if (regs[14] !== 8'h3E) begin bad++; $display("FAIL noterm_reg14 got=%h exp=3e", regs[14]); end
    total++; if (regs[15] !== 8'hEE) begin bad++; $display("FAIL noterm_reg15 got=%h exp=ee", regs[15]); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int cyc;
    for (int i = 0; i < 16; i++) rom[i] = 8'hFF;
    for (int i = 0; i < 6; i++) rom[i] = 8'hA0 + 8'(i);
    clear_model();
    pulse_start();
    cyc = 1;
    goto(cyc, 1 + 3 * ENTRY + 1 + P + H + 1);
    total++; if ({a_d, wr_n} !== 2'b10 || ad_out !== 8'hA3) begin bad++; $display("FAIL mid_in_data_lo got=%b%b/%h exp=10/a3", a_d, wr_n, ad_out); end
    #2 reset_n = 1'b0;
    #1;
    total++; if ({cs_n, wr_n, a_d} !== 3'b110 || ad_out !== 8'h00) begin bad++; $display("FAIL mid_bus_inactive got=%b%b%b/%h exp=110/00", cs_n, wr_n, a_d, ad_out); end
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL mid_busy_done got=%b/%b exp=0/0", busy, done); end
    @(negedge clk) reset_n = 1'b1;
    repeat (4) @(negedge clk);
    total++; if (cs_n !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL mid_no_resume got=cs_n%b/busy%b exp=1/0", cs_n, busy); end
    clear_model();
    pulse_start();
    cyc = 1;
    goto(cyc, 2);
    total++; if (ad_out !== 8'h00 || wr_n !== 1'b0) begin bad++; $display("FAIL mid_restart_idx0 got=%h/%b exp=00/0", ad_out, wr_n); end
    wait_done(cyc, 400);
    total++; if (cyc !== 1 + 6 * ENTRY + 1) begin bad++; $display("FAIL mid_restart_done got=%0d exp=%0d", cyc, 1 + 6 * ENTRY + 1); end
    total++; if (nwrites !== 6 || regs[3] !== 8'hA3) begin bad++; $display("FAIL mid_restart_writes got=%0d/%h exp=6/a3", nwrites, regs[3]); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int cyc;
    int cs_snap;
    load_table1();
    clear_model();
    pulse_start();
    cyc = 1;
    goto(cyc, 20);
    start = 1'b1;
    goto(cyc, 21);
    start = 1'b0;
    wait_done(cyc, 400);
    total++; if (cyc !== 1 + 9 * ENTRY + 1) begin bad++; $display("FAIL b2b_done_cycle got=%0d exp=%0d", cyc, 1 + 9 * ENTRY + 1); end
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL b2b_start_at_done got=busy%b/done%b exp=0/0", busy, done); end
    cs_snap = cs_cycles;
    repeat (6) @(negedge clk);
    total++; if (cs_cycles !== cs_snap || busy !== 1'b0) begin bad++; $display("FAIL b2b_no_second_run got=%0d/%b exp=%0d/0", cs_cycles, busy, cs_snap); end
    total++; if (nwrites !== 9) begin bad++; $display("FAIL b2b_nwrites got=%0d exp=9", nwrites); end
  endtask

`ifdef RTC_INIT_READBACK_EN
  task automatic test_readback();
    int cyc;
    load_table1();
    clear_model();
    bad_reg4 = 1'b1;
    pulse_start();
    cyc = 1;
    goto(cyc, 1 + 4 * ENTRY);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rb_err_before4 got=%b exp=0", err); end
    goto(cyc, 1 + 5 * ENTRY);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL rb_err_after4 got=%b exp=1", err); end
    wait_done(cyc, 600);
    total++; if (cyc !== 1 + 9 * ENTRY + 1) begin bad++; $display("FAIL rb_done_cycle got=%0d exp=%0d", cyc, 1 + 9 * ENTRY + 1); end
    repeat (3) @(negedge clk);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL rb_err_sticky got=%b exp=1", err); end
    bad_reg4 = 1'b0;
    rom[0] = 8'hFF;
    pulse_start();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rb_err_cleared got=%b exp=0", err); end
    repeat (3) @(negedge clk);
  endtask
`endif

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 8'hFF;
    clear_model();
    test_reset();
    test_table_run();
    test_first_term();
    test_no_term();
    test_reset_mid();
    test_back_to_back();
`ifdef RTC_INIT_READBACK_EN
    test_readback();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rtc_init_sequencer.md
RTC_INIT_SEQUENCER -- requirements
Module: rtc_init_sequencer

Interface
REQ-001 Parameter PULSE_CYC, default 4: cycles wr_n (and rd_n) is held low per strobe.
REQ-002 Parameter HOLD_CYC, default 2: cycles the strobe is high before the next phase begins.
REQ-003 clk  input  1  single system clock; all logic rises on posedge clk.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to run the init table.
REQ-006 rom_addr  output  4  table index presented to the combinational init ROM.
REQ-007 rom_data  input  8  ROM byte for rom_addr, valid in the same cycle.
REQ-008 cs_n  output  1  RTC chip select, active low.
REQ-009 a_d  output  1  bus phase: 0 = address, 1 = data.
REQ-010 wr_n  output  1  RTC write strobe, active low.
REQ-011 ad_out  output  8  multiplexed address/data bus to the RTC.
REQ-012 busy  output  1  high from the cycle after start is accepted until done.
REQ-013 done  output  1  one-cycle pulse when the table finishes.

Function
REQ-014 FSM states: IDLE, FETCH, ADDR_LO, ADDR_HI, DATA_LO, DATA_HI, FINISH.
REQ-015 IDLE: start=1 gives idx<=0, busy<=1, ->FETCH; start is ignored in every other state.
REQ-016 FETCH: rom_addr=idx; if rom_data==8'hFF or idx==4'hF ->FINISH, else latch rom_data into data_reg ->ADDR_LO.
REQ-017 ADDR_LO, PULSE_CYC cycles: cs_n=0, a_d=0, wr_n=0, ad_out={4'h0,idx}.
REQ-018 ADDR_HI, HOLD_CYC cycles: cs_n=0, a_d=0, wr_n=1, ad_out unchanged, ->DATA_LO.
REQ-019 DATA_LO, PULSE_CYC cycles: cs_n=0, a_d=1, wr_n=0, ad_out=data_reg.
REQ-020 DATA_HI, HOLD_CYC cycles: cs_n=0, a_d=1, wr_n=1, then idx<=idx+1 ->FETCH.
REQ-021 A single phase-cycle counter, cleared on every state change, sets all phase lengths.
REQ-022 Each table entry written costs 1+2*(PULSE_CYC+HOLD_CYC) cycles, which is 13 at the defaults.
REQ-023 FINISH: done=1 and busy<=0 for one cycle, then ->IDLE.
REQ-024 Outside ADDR_*/DATA_*: cs_n=1, wr_n=1, a_d=0, ad_out=8'h00.
REQ-025 idx never wraps: index 15 is always treated as the terminator, so at most 15 writes are made.
REQ-026 If start and done coincide, start is ignored; a new run needs a start pulse while in IDLE.

Reset
REQ-027 reset_n low at any time, including mid-strobe, gives immediately (asynchronously): state=IDLE, idx=0, counter=0, cs_n=1, wr_n=1, a_d=0, ad_out=8'h00, busy=0, done=0.
REQ-028 After reset_n is released, the block waits in IDLE for a new start; an interrupted run is never resumed.

Configuration
REQ-029 Macro RTC_INIT_READBACK_EN, when defined, adds these ports:
- rd_n  output  1
- ad_in  input  8
- err  output  1, sticky, cleared on start
REQ-030 With RTC_INIT_READBACK_EN defined, each write is followed by a readback:
- a second address phase
- then a read phase: rd_n=0 for PULSE_CYC cycles, sampled on the last low cycle
- then rd_n=1 for HOLD_CYC cycles
- ad_in!=data_reg sets err
REQ-031 Without RTC_INIT_READBACK_EN: no rd_n, ad_in or err ports, and no readback phases.

Structure
REQ-032 Shared package rtc_pkg holds:
- the state enum
- RTC_TERM = 8'hFF
- IDX_MAX = 4'hF
- the default PULSE_CYC and HOLD_CYC values
REQ-033 Sub-module rtc_bus_strobe (phase counter plus strobe and hold timing) is instantiated once.
REQ-034 The ROM stays external; this block only drives rom_addr and samples rom_data.

Verification
REQ-035 The bench covers these directed scenarios:
- Init table {00,00,00,00,01,01,00,00,00,FF}, start -> 9 write pairs, registers 0..8 receive those bytes, done at cycle 1+9*13+1 after start.
- Table with entry 0 = FF -> no cs_n activity, done two cycles after start.
- Table with no FF -> exactly 15 writes (idx 0..14), then done.
- reset_n low during DATA_LO of entry 3 -> all bus lines inactive in the same cycle, busy=0; the next start restarts at idx 0.
- start pulsed while busy, and again coincident with done -> both ignored, a single run is observed.
- RTC_INIT_READBACK_EN defined, model returns 8'h5A for register 4 (expected 8'h01) -> err=1 after entry 4 and stays set until the next start.
